// File: rtl/gb_oam_dma.sv
// OAM DMA engine: an FF46 write copies LEN bytes from page {V,8'h00} into OAM and owns the system address bus meanwhile.
// Optional CPU access blocking during transfers is enabled by defining GB_OAM_DMA_CPU_BLOCK_EN.
module gb_oam_dma #(
    parameter int LEN         = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ce,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_write,
    input  logic [7:0]  mem_data,
    output logic [15:0] adr_out,
    output logic [7:0]  reg_data,
    output logic        dma_active,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_data,
    output logic        oam_write,
    output logic        cpu_block
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam logic [7:0] DCNT_INIT = 8'(START_DELAY - 1);
    localparam logic [7:0] IDX_LAST  = 8'(LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] base_q;
    logic       reg_wr;
    logic       rd_issue;

    // read stage: a source byte was addressed on the previous ce tick
    logic       vld_p1;
    logic [7:0] pidx_p1;

    assign reg_wr     = ce & cpu_write & (cpu_adr == 16'hFF46);
    assign dma_active = (state_q == XFER);
    // a restart tick drops its own read so only the previously fetched byte lands
    assign rd_issue   = dma_active & ~reg_wr;
    assign adr_out    = dma_active ? {base_q, idx_q} : cpu_adr;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (reg_wr) begin
                    state_d = START;
                    dcnt_d  = DCNT_INIT;
                end
            end
            START: begin
                if (reg_wr) begin
                    dcnt_d = DCNT_INIT;
                end else if (dcnt_q == 8'd0) begin
                    state_d = XFER;
                    idx_d   = 8'd0;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
            XFER: begin
                if (reg_wr) begin
                    state_d = START;
                    dcnt_d  = DCNT_INIT;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            dcnt_q    <= 8'd0;
            idx_q     <= 8'd0;
            reg_data  <= 8'h00;
            vld_p1    <= 1'b0;
            oam_write <= 1'b0;
            oam_adr   <= 8'd0;
            oam_data  <= 8'd0;
        end else begin
            oam_write <= 1'b0;
            if (ce) begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                idx_q   <= idx_d;
                vld_p1  <= rd_issue;
                if (reg_wr) begin
                    reg_data <= cpu_data;
                end
                // write stage: returned byte goes into OAM one ce tick after its address
                if (vld_p1) begin
                    oam_write <= 1'b1;
                    oam_data  <= mem_data;
                    oam_adr   <= pidx_p1;
                end
            end
        end
    end

    // FE/FF source pages fold onto the WRAM mirror so OAM and IO are never read back
    always_ff @(posedge clk) begin
        if (ce) begin
            pidx_p1 <= idx_q;
            if (reg_wr) begin
                base_q <= (cpu_data >= 8'hE0) ? (cpu_data & 8'hDF) : cpu_data;
            end
        end
    end

`ifdef GB_OAM_DMA_CPU_BLOCK_EN
    assign cpu_block = dma_active & ~((cpu_adr >= 16'hFF80) && (cpu_adr <= 16'hFFFE))
                       & (cpu_adr != 16'hFF46);
`else
    assign cpu_block = 1'b0;
`endif

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: table of source pages plus restart, reset, ce-gating and block sequences,
// with a write scoreboard fed by a bus-read monitor.
module tb_gb_oam_dma;

    localparam int LEN = 160;

    logic        clk;
    logic        nreset;
    logic        ce;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_data;
    logic        cpu_write;
    logic [7:0]  mem_data;
    logic [15:0] adr_out;
    logic [7:0]  reg_data;
    logic        dma_active;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_data;
    logic        oam_write;
    logic        cpu_block;

    gb_oam_dma #(.LEN(LEN), .START_DELAY(1)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .ce         (ce),
        .cpu_adr    (cpu_adr),
        .cpu_data   (cpu_data),
        .cpu_write  (cpu_write),
        .mem_data   (mem_data),
        .adr_out    (adr_out),
        .reg_data   (reg_data),
        .dma_active (dma_active),
        .oam_adr    (oam_adr),
        .oam_data   (oam_data),
        .oam_write  (oam_write),
        .cpu_block  (cpu_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // source memory: returns data for the address presented on the previous ce tick
    logic [15:0] mem_adr_q;
    always @(posedge clk) begin
        if (ce) mem_adr_q <= adr_out;
    end
    assign mem_data = mem_adr_q[7:0] ^ 8'h5A;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] page_in;
        logic [7:0] exp_page;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];

    int         n_pass = 0;
    int         n_total = 0;
    int         wr_count = 0;
    logic [7:0] last_wr_adr = 8'd0;
    logic [7:0] exp_page = 8'd0;
    logic [7:0] exp_next_idx = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // read-tick monitor and write scoreboard, both sampled on the falling edge
    always @(negedge clk) begin
        if (nreset) begin
            if (ce && dma_active && !(cpu_write && cpu_adr == 16'hFF46)) begin
                chk("src_adr", {16'h0, adr_out}, {16'h0, exp_page, exp_next_idx});
                exp_q.push_back('{adr: exp_next_idx, data: exp_next_idx ^ 8'h5A});
                exp_next_idx = exp_next_idx + 8'd1;
            end
            if (oam_write) begin
                wr_t e;
                chk("write_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("oam_adr", {24'h0, oam_adr}, {24'h0, e.adr});
                    chk("oam_data", {24'h0, oam_data}, {24'h0, e.data});
                end
                wr_count++;
                last_wr_adr = oam_adr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ff46(input logic [7:0] d);
        exp_next_idx = 8'd0;
        cpu_adr   = 16'hFF46;
        cpu_data  = d;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
        cpu_adr   = 16'h1234;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!dma_active) begin
                done = 1;
                break;
            end
        end
        chk("idle_timeout", {31'h0, done}, 32'h1);
        repeat (3) tick();
    endtask

    task automatic wait_idx(input logic [7:0] n);
        bit done = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (dma_active && adr_out[7:0] == n) begin
                done = 1;
                break;
            end
        end
        chk("idx_timeout", {31'h0, done}, 32'h1);
    endtask

    logic [15:0] saved_adr;
    logic [7:0]  saved_oadr;
    int          saved_wr;

    initial begin
        vecs[0] = '{page_in: 8'hC1, exp_page: 8'hC1};
        vecs[1] = '{page_in: 8'hFE, exp_page: 8'hDE};
        vecs[2] = '{page_in: 8'hFF, exp_page: 8'hDF};
        vecs[3] = '{page_in: 8'hE0, exp_page: 8'hC0};
        vecs[4] = '{page_in: 8'hDF, exp_page: 8'hDF};
        vecs[5] = '{page_in: 8'h00, exp_page: 8'h00};

        nreset = 1'b0; ce = 1'b1; cpu_adr = 16'h1234; cpu_data = 8'h00; cpu_write = 1'b0;
        repeat (3) tick();
        chk("rst_reg_data", {24'h0, reg_data}, 32'h0);
        chk("rst_dma_active", {31'h0, dma_active}, 32'h0);
        chk("rst_oam_write", {31'h0, oam_write}, 32'h0);
        chk("rst_oam_adr", {24'h0, oam_adr}, 32'h0);
        chk("rst_oam_data", {24'h0, oam_data}, 32'h0);
        chk("rst_cpu_block", {31'h0, cpu_block}, 32'h0);
        chk("rst_adr_out", {16'h0, adr_out}, 32'h1234);
        nreset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            exp_page = vecs[v].exp_page;
            wr_count = 0;
            write_ff46(vecs[v].page_in);
            chk("start_not_active", {31'h0, dma_active}, 32'h0);
            chk("reg_data", {24'h0, reg_data}, {24'h0, vecs[v].page_in});
            tick();
            chk("first_active", {31'h0, dma_active}, 32'h1);
            chk("first_adr", {16'h0, adr_out}, {16'h0, vecs[v].exp_page, 8'h00});
            chk("idle_cpu_block", {31'h0, cpu_block}, 32'h0);
            wait_idle();
            chk("write_count", wr_count, LEN);
            chk("last_write_adr", {24'h0, last_wr_adr}, LEN - 1);
            chk("queue_drained", exp_q.size(), 0);
        end

        // restart at idx 50
        exp_page = 8'h80;
        wr_count = 0;
        write_ff46(8'h80);
        wait_idx(8'd50);
        exp_page = 8'h90;
        write_ff46(8'h90);
        chk("restart_pending_write", {31'h0, oam_write}, 32'h1);
        chk("restart_pending_adr", {24'h0, oam_adr}, 32'd49);
        chk("restart_in_start", {31'h0, dma_active}, 32'h0);
        tick();
        chk("restart_first_adr", {16'h0, adr_out}, 32'h9000);
        wait_idle();
        chk("restart_write_count", wr_count, 50 + LEN);
        chk("restart_reg_data", {24'h0, reg_data}, 32'h90);

        // async reset at idx 100
        exp_page = 8'hC1;
        write_ff46(8'hC1);
        wait_idx(8'd100);
        nreset = 1'b0;
        #1;
        exp_q.delete();
        chk("reset_dma_active", {31'h0, dma_active}, 32'h0);
        chk("reset_oam_write", {31'h0, oam_write}, 32'h0);
        chk("reset_adr_out", {16'h0, adr_out}, {16'h0, cpu_adr});
        chk("reset_reg_data", {24'h0, reg_data}, 32'h0);
        saved_wr = wr_count;
        repeat (2) tick();
        nreset = 1'b1;
        repeat (5) tick();
        chk("reset_no_writes", wr_count, saved_wr);
        chk("reset_stays_idle", {31'h0, dma_active}, 32'h0);

        // ce held low for 7 clocks mid-transfer, with cpu_block probes
        exp_page = 8'hC1;
        wr_count = 0;
        write_ff46(8'hC1);
        wait_idx(8'd30);
        saved_adr  = adr_out;
        saved_oadr = oam_adr;
        ce = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cpu_adr = (i % 2 == 0) ? 16'hFF90 : 16'hC000;
            tick();
            chk("frozen_adr", {16'h0, adr_out}, {16'h0, saved_adr});
            chk("frozen_no_write", {31'h0, oam_write}, 32'h0);
            chk("frozen_oam_adr", {24'h0, oam_adr}, {24'h0, saved_oadr});
`ifdef GB_OAM_DMA_CPU_BLOCK_EN
            chk("cpu_block", {31'h0, cpu_block}, (i % 2 == 0) ? 32'h0 : 32'h1);
`else
            chk("cpu_block", {31'h0, cpu_block}, 32'h0);
`endif
        end
        cpu_adr = 16'h1234;
        ce = 1'b1;
        wait_idle();
        chk("gated_write_count", wr_count, LEN);
        chk("gated_queue_drained", exp_q.size(), 0);
        cpu_adr = 16'hC000;
        #1;
        chk("idle_cpu_block_c000", {31'h0, cpu_block}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
